// File: rtl/mem_lsu_stage.sv
// MEM/LSU pipeline stage: registers the EX bundle, waits out the data SRAM
// read latency for loads, holds load data across WB stalls and extracts the
// load result (LW/LB/LBU/LH/LHU) for write-back and forwarding.
// Ports: clk, resetn (async active-low), stall bus, flush, ex_* bundle in,
// data_sram_rdata in; stallreq_mem and wb_* bundle out (combinational).
module mem_lsu_stage #(
    parameter int RD_LAT  = 1,
    parameter int STALL_W = 6,
    parameter bit HILO_EN = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic               ex_mem_re,
    input  logic               ex_rf_we,
    input  logic               ex_hi_we,
    input  logic               ex_lo_we,
    input  logic [31:0]        ex_pc,
    input  logic [2:0]         ex_ld_type,
    input  logic [1:0]         ex_addr_lo,
    input  logic [4:0]         ex_rf_waddr,
    input  logic [31:0]        ex_result,
    input  logic [31:0]        ex_hi_wdata,
    input  logic [31:0]        ex_lo_wdata,
    input  logic [31:0]        data_sram_rdata,
    output logic               stallreq_mem,
    output logic               wb_valid,
    output logic               wb_rf_we,
    output logic               wb_hi_we,
    output logic               wb_lo_we,
    output logic [31:0]        wb_pc,
    output logic [4:0]         wb_rf_waddr,
    output logic [31:0]        wb_rf_wdata,
    output logic [31:0]        wb_hi_wdata,
    output logic [31:0]        wb_lo_wdata
);

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_WAIT  = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    localparam logic [2:0] LAST = 3'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        cap, bub;

    logic        valid_q, mem_re_q, rf_we_q, hi_we_q, lo_we_q;
    logic [31:0] pc_q, result_q, hi_q, lo_q;
    logic [2:0]  ld_type_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rf_waddr_q;

    logic        is_load, in_wait;
    logic [31:0] raw, shifted, ext;
    logic [15:0] half;
    logic        unused_ok;

    // Only the MEM (3) and WB (4) hold bits matter to this stage.
    assign unused_ok = &{1'b0, stall};

    assign is_load = valid_q & mem_re_q;
    assign in_wait = is_load && (state_q == S_WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        cap     = 1'b0;
        bub     = 1'b0;
        if (flush) begin
            bub = 1'b1;
        end else if (stall[3] && !stall[4]) begin
            bub = 1'b1;
        end else if (!stall[3]) begin
            cap    = 1'b1;
            cnt_d  = 3'd0;
            hold_d = 32'd0;
            if (ex_valid && ex_mem_re && (LAST != 3'd0))
                state_d = S_WAIT;
            else
                state_d = S_READY;
        end else if (is_load) begin
            unique case (state_q)
                S_WAIT: begin
                    cnt_d = 3'(cnt_q + 3'd1);
                    if (cnt_d == LAST)
                        state_d = S_READY;
                end
                S_READY: begin
                    // WB is stalled: the SRAM word may vanish, keep a copy.
                    if (stall[4]) begin
                        hold_d  = data_sram_rdata;
                        state_d = S_HELD;
                    end
                end
                default: ;
            endcase
        end
        if (bub) begin
            state_d = S_READY;
            cnt_d   = 3'd0;
            hold_d  = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_READY;
            cnt_q      <= 3'd0;
            hold_q     <= 32'd0;
            valid_q    <= 1'b0;
            mem_re_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            hi_we_q    <= 1'b0;
            lo_we_q    <= 1'b0;
            pc_q       <= 32'd0;
            ld_type_q  <= 3'd0;
            addr_lo_q  <= 2'd0;
            rf_waddr_q <= 5'd0;
            result_q   <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            if (bub) begin
                valid_q    <= 1'b0;
                mem_re_q   <= 1'b0;
                rf_we_q    <= 1'b0;
                hi_we_q    <= 1'b0;
                lo_we_q    <= 1'b0;
                pc_q       <= 32'd0;
                ld_type_q  <= 3'd0;
                addr_lo_q  <= 2'd0;
                rf_waddr_q <= 5'd0;
                result_q   <= 32'd0;
                hi_q       <= 32'd0;
                lo_q       <= 32'd0;
            end else if (cap) begin
                valid_q    <= ex_valid;
                mem_re_q   <= ex_mem_re;
                rf_we_q    <= ex_rf_we;
                hi_we_q    <= ex_hi_we;
                lo_we_q    <= ex_lo_we;
                pc_q       <= ex_pc;
                ld_type_q  <= ex_ld_type;
                addr_lo_q  <= ex_addr_lo;
                rf_waddr_q <= ex_rf_waddr;
                result_q   <= ex_result;
                hi_q       <= ex_hi_wdata;
                lo_q       <= ex_lo_wdata;
            end
        end
    end

    assign raw     = (state_q == S_HELD) ? hold_q : data_sram_rdata;
    assign shifted = raw >> {addr_lo_q, 3'b000};
    assign half    = addr_lo_q[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        ext = raw;
        unique case (ld_type_q)
            3'b001:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b010:  ext = {24'd0, shifted[7:0]};
            3'b011:  ext = {{16{half[15]}}, half};
            3'b100:  ext = {16'd0, half};
            default: ext = raw;
        endcase
    end

    assign stallreq_mem = in_wait;
    assign wb_valid     = valid_q & ~in_wait;
    assign wb_rf_we     = rf_we_q & wb_valid;
    assign wb_hi_we     = HILO_EN & hi_we_q & wb_valid;
    assign wb_lo_we     = HILO_EN & lo_we_q & wb_valid;
    assign wb_pc        = pc_q;
    assign wb_rf_waddr  = rf_waddr_q;
    assign wb_rf_wdata  = is_load ? ext : result_q;
    assign wb_hi_wdata  = HILO_EN ? hi_q : 32'd0;
    assign wb_lo_wdata  = HILO_EN ? lo_q : 32'd0;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed testbench for mem_lsu_stage: four instances share stimulus
// (RD_LAT 1/3/4 with hi/lo, and RD_LAT 1 with hi/lo disabled).
module tb_mem_lsu_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  stall;
    logic        flush;
    logic        ex_valid, ex_mem_re, ex_rf_we, ex_hi_we, ex_lo_we;
    logic [31:0] ex_pc, ex_result, ex_hi_wdata, ex_lo_wdata;
    logic [2:0]  ex_ld_type;
    logic [1:0]  ex_addr_lo;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] rdata;

    logic [3:0]  stallreq, wb_valid, wb_rf_we, wb_hi_we, wb_lo_we;
    logic [31:0] wb_pc [4];
    logic [4:0]  wb_rf_waddr [4];
    logic [31:0] wb_rf_wdata [4];
    logic [31:0] wb_hi_wdata [4];
    logic [31:0] wb_lo_wdata [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 1) ? 3 : (g == 2) ? 4 : 1;
        localparam bit HL  = (g == 3) ? 1'b0 : 1'b1;
        mem_lsu_stage #(.RD_LAT(LAT), .STALL_W(6), .HILO_EN(HL)) u_dut (
            .clk             (clk),
            .resetn          (resetn),
            .stall           (stall),
            .flush           (flush),
            .ex_valid        (ex_valid),
            .ex_mem_re       (ex_mem_re),
            .ex_rf_we        (ex_rf_we),
            .ex_hi_we        (ex_hi_we),
            .ex_lo_we        (ex_lo_we),
            .ex_pc           (ex_pc),
            .ex_ld_type      (ex_ld_type),
            .ex_addr_lo      (ex_addr_lo),
            .ex_rf_waddr     (ex_rf_waddr),
            .ex_result       (ex_result),
            .ex_hi_wdata     (ex_hi_wdata),
            .ex_lo_wdata     (ex_lo_wdata),
            .data_sram_rdata (rdata),
            .stallreq_mem    (stallreq[g]),
            .wb_valid        (wb_valid[g]),
            .wb_rf_we        (wb_rf_we[g]),
            .wb_hi_we        (wb_hi_we[g]),
            .wb_lo_we        (wb_lo_we[g]),
            .wb_pc           (wb_pc[g]),
            .wb_rf_waddr     (wb_rf_waddr[g]),
            .wb_rf_wdata     (wb_rf_wdata[g]),
            .wb_hi_wdata     (wb_hi_wdata[g]),
            .wb_lo_wdata     (wb_lo_wdata[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid    = 1'b0;
        ex_mem_re   = 1'b0;
        ex_rf_we    = 1'b0;
        ex_hi_we    = 1'b0;
        ex_lo_we    = 1'b0;
        ex_pc       = 32'd0;
        ex_ld_type  = 3'd0;
        ex_addr_lo  = 2'd0;
        ex_rf_waddr = 5'd0;
        ex_result   = 32'd0;
        ex_hi_wdata = 32'd0;
        ex_lo_wdata = 32'd0;
    endtask

    task automatic ex_load(input logic [2:0] t, input logic [1:0] a);
        ex_idle();
        ex_valid    = 1'b1;
        ex_mem_re   = 1'b1;
        ex_rf_we    = 1'b1;
        ex_ld_type  = t;
        ex_addr_lo  = a;
        ex_rf_waddr = 5'd5;
        ex_pc       = 32'h100;
        ex_result   = 32'hDEAD0000;
    endtask

    typedef struct {
        logic [2:0]  t;
        logic [1:0]  a;
        logic [31:0] rd;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t vecs [9] = '{
        '{3'b000, 2'd0, 32'h89ABCDEF, 32'h89ABCDEF},
        '{3'b001, 2'd2, 32'h12803456, 32'hFFFFFF80},
        '{3'b010, 2'd2, 32'h12803456, 32'h00000080},
        '{3'b001, 2'd1, 32'h12807F56, 32'h0000007F},
        '{3'b011, 2'd0, 32'h1234F00D, 32'hFFFFF00D},
        '{3'b011, 2'd3, 32'h80001234, 32'hFFFF8000},
        '{3'b100, 2'd1, 32'hBEEF9234, 32'h00009234},
        '{3'b111, 2'd0, 32'hCAFEBABE, 32'hCAFEBABE},
        '{3'b010, 2'd3, 32'hA1000000, 32'h000000A1}
    };

    initial begin
        resetn = 1'b0;
        stall  = 6'd0;
        flush  = 1'b0;
        rdata  = 32'd0;
        ex_idle();
        #12;
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_wdata", wb_rf_wdata[0], 32'd0);
        chk("rst_pc", wb_pc[2], 32'd0);
        #5 resetn = 1'b1;
        tick();
        chk("post_rst_valid", 32'(wb_valid), 32'd0);

        // Load extraction, RD_LAT=1: data in the capture cycle.
        foreach (vecs[i]) begin
            ex_load(vecs[i].t, vecs[i].a);
            tick();
            ex_idle();
            rdata = vecs[i].rd;
            #1;
            chk($sformatf("ld%0d_data", i), wb_rf_wdata[0], vecs[i].exp);
            chk($sformatf("ld%0d_stall", i), 32'(stallreq[0]), 32'd0);
            chk($sformatf("ld%0d_we", i), 32'(wb_rf_we[0]), 32'd1);
        end
        chk("ld_waddr", 32'(wb_rf_waddr[0]), 32'd5);

        // Non-load with hi/lo.
        ex_idle();
        ex_valid    = 1'b1;
        ex_rf_we    = 1'b1;
        ex_hi_we    = 1'b1;
        ex_lo_we    = 1'b1;
        ex_result   = 32'h1234;
        ex_hi_wdata = 32'h11;
        ex_lo_wdata = 32'h22;
        ex_pc       = 32'h200;
        tick();
        ex_idle();
        chk("nl_wdata", wb_rf_wdata[1], 32'h1234);
        chk("nl_stall", 32'(stallreq[1]), 32'd0);
        chk("nl_valid", 32'(wb_valid[1]), 32'd1);
        chk("nl_hi_we", 32'(wb_hi_we[0]), 32'd1);
        chk("nl_hi", wb_hi_wdata[0], 32'h11);
        chk("nl_lo", wb_lo_wdata[0], 32'h22);
        chk("nl_pc", wb_pc[0], 32'h200);
        chk("nohl_hi_we", 32'(wb_hi_we[3]), 32'd0);
        chk("nohl_lo_we", 32'(wb_lo_we[3]), 32'd0);
        chk("nohl_hi", wb_hi_wdata[3], 32'd0);
        chk("nohl_lo", wb_lo_wdata[3], 32'd0);

        // RD_LAT=3, LHU addr_lo=2.
        ex_load(3'b100, 2'd2);
        rdata = 32'd0;
        tick();
        ex_idle();
        stall = 6'b011000;
        chk("l3_c0_stall", 32'(stallreq[1]), 32'd1);
        chk("l3_c0_valid", 32'(wb_valid[1]), 32'd0);
        chk("l3_c0_we", 32'(wb_rf_we[1]), 32'd0);
        tick();
        chk("l3_c1_stall", 32'(stallreq[1]), 32'd1);
        chk("l3_c1_valid", 32'(wb_valid[1]), 32'd0);
        rdata = 32'hBEEF1234;
        tick();
        chk("l3_c2_stall", 32'(stallreq[1]), 32'd0);
        chk("l3_c2_valid", 32'(wb_valid[1]), 32'd1);
        chk("l3_c2_data", wb_rf_wdata[1], 32'h0000BEEF);
        stall = 6'd0;
        tick();

        // RD_LAT=1 LW held across a WB stall.
        ex_load(3'b000, 2'd0);
        rdata = 32'hAAAA5555;
        tick();
        ex_idle();
        chk("hold_c0", wb_rf_wdata[0], 32'hAAAA5555);
        stall = 6'b011000;
        tick();
        rdata = 32'd0;
        #1;
        chk("hold_c1", wb_rf_wdata[0], 32'hAAAA5555);
        chk("hold_c1_valid", 32'(wb_valid[0]), 32'd1);
        tick();
        chk("hold_c2", wb_rf_wdata[0], 32'hAAAA5555);
        stall = 6'd0;
        tick();
        chk("hold_rel_valid", 32'(wb_valid[0]), 32'd0);
        chk("hold_rel_data", wb_rf_wdata[0], 32'd0);

        // MEM held, WB free: bubble.
        ex_idle();
        ex_valid  = 1'b1;
        ex_rf_we  = 1'b1;
        ex_result = 32'h1234;
        tick();
        chk("bub_pre_valid", 32'(wb_valid[0]), 32'd1);
        stall = 6'b001000;
        tick();
        chk("bub_valid", 32'(wb_valid[0]), 32'd0);
        chk("bub_we", 32'(wb_rf_we[0]), 32'd0);
        chk("bub_data", wb_rf_wdata[0], 32'd0);
        stall = 6'd0;
        ex_idle();

        // Flush during WAIT, RD_LAT=4 at cnt=1.
        ex_load(3'b000, 2'd0);
        tick();
        ex_idle();
        stall = 6'b011000;
        tick();
        chk("fl_wait", 32'(stallreq[2]), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_stall", 32'(stallreq[2]), 32'd0);
        chk("fl_valid", 32'(wb_valid[2]), 32'd0);
        chk("fl_pc", wb_pc[2], 32'd0);
        chk("fl_waddr", 32'(wb_rf_waddr[2]), 32'd0);
        chk("fl_data", wb_rf_wdata[2], 32'd0);
        stall = 6'd0;

        // Reset mid-WAIT, then first capture passes hi/lo.
        ex_load(3'b000, 2'd0);
        ex_hi_we    = 1'b1;
        ex_hi_wdata = 32'h55;
        tick();
        ex_idle();
        stall = 6'b011000;
        chk("rw_wait", 32'(stallreq[2]), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rw_stall", 32'(stallreq[2]), 32'd0);
        chk("rw_hi_we", 32'(wb_hi_we[2]), 32'd0);
        chk("rw_hi", wb_hi_wdata[2], 32'd0);
        chk("rw_pc", wb_pc[2], 32'd0);
        tick();
        resetn = 1'b1;
        stall  = 6'd0;
        ex_valid    = 1'b1;
        ex_hi_we    = 1'b1;
        ex_lo_we    = 1'b1;
        ex_hi_wdata = 32'h77;
        ex_lo_wdata = 32'h88;
        #1;
        chk("rw_rel_valid", 32'(wb_valid[2]), 32'd0);
        tick();
        ex_idle();
        chk("rw_cap_valid", 32'(wb_valid[2]), 32'd1);
        chk("rw_cap_hi_we", 32'(wb_hi_we[2]), 32'd1);
        chk("rw_cap_lo_we", 32'(wb_lo_we[2]), 32'd1);
        chk("rw_cap_hi", wb_hi_wdata[2], 32'h77);
        chk("rw_cap_lo", wb_lo_wdata[2], 32'h88);
        chk("rw_cap_stall", 32'(stallreq[2]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
